// File: rtl/ltc2324_sched.sv
`default_nettype none
// ============================================================================
// Module      : ltc2324_sched
// Description : Conversion scheduler for an LTC2324 ADC core. Issues
//               single-cycle start requests at a programmable period, in
//               continuous mode or as software-triggered bursts. Slots that
//               cannot be used because the channel FIFOs are full are counted
//               as overruns.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        width of period, burst and statistics counters
//   TIMEOUT_CYC  CONV cycles allowed before a watchdog timeout
// Optional feature
//   LTC2324_SCHED_TIMEOUT_EN  when defined, a CONV watchdog sets timeout_err_o
//                             and returns to IDLE; otherwise CONV waits forever
//                             and timeout_err_o is constant 0.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable_i        scheduler enable (level)
//   burst_mode_i    0 = continuous, 1 = burst of burst_len_i per sw_trig_i
//   period_i        cycles between start pulses
//   burst_len_i     samples per burst
//   sw_trig_i       single-cycle burst trigger
//   fifo_ready_i    all channel FIFOs can take one word
//   core_valid_i    conversion result strobe from the ADC core
//   clr_stat_i      clears overrun_cnt_o and timeout_err_o
//   start_o         single-cycle conversion request
//   busy_o          scheduler not idle
//   done_o          single-cycle burst completion pulse
//   overrun_cnt_o   saturating count of skipped sample slots
//   timeout_err_o   sticky conversion timeout flag
// ============================================================================
module ltc2324_sched #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             burst_mode_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic             sw_trig_i,
    input  logic             fifo_ready_i,
    input  logic             core_valid_i,
    input  logic             clr_stat_i,
    output logic             start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] overrun_cnt_o,
    output logic             timeout_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CONV = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   ovr_q, ovr_d;
    logic [CNT_W-1:0]   per_sh_q, per_sh_d;    // shadow period (>= 2)
    logic [CNT_W-1:0]   blen_sh_q, blen_sh_d;  // shadow burst length (>= 1)
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // period down-counter
    logic [CNT_W-1:0]   smp_q, smp_d;          // samples taken this run
    logic               stop_q, stop_d;        // enable dropped during CONV
    logic [CNT_W-1:0]   w_cnt_dec;
    logic               w_ovr_inc;

`ifdef LTC2324_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               terr_q, terr_d;
    logic               w_to_set;
`endif

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        done_d    = 1'b0;
        per_sh_d  = per_sh_q;
        blen_sh_d = blen_sh_q;
        cnt_d     = cnt_q;
        smp_d     = smp_q;
        stop_d    = stop_q;
        w_ovr_inc = 1'b0;
`ifdef LTC2324_SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        w_to_set  = 1'b0;
`endif
        // The down-counter holds at zero instead of wrapping.
        w_cnt_dec = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (enable_i && (!burst_mode_i || sw_trig_i)) begin
                    state_d   = S_WAIT;
                    per_sh_d  = (period_i < CNT_W'(2)) ? CNT_W'(2) : period_i;
                    blen_sh_d = (burst_len_i == '0) ? CNT_W'(1) : burst_len_i;
                    cnt_d     = '0;
                    smp_d     = '0;
                end
            end
            S_WAIT: begin
                cnt_d = w_cnt_dec;
                if (!enable_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    // A slot is due: either use it or record it as skipped.
                    cnt_d = per_sh_q - 1'b1;
                    if (fifo_ready_i) begin
                        start_d = 1'b1;
                        state_d = S_CONV;
`ifdef LTC2324_SCHED_TIMEOUT_EN
                        wd_d    = '0;
`endif
                    end else begin
                        w_ovr_inc = 1'b1;
                    end
                end
            end
            S_CONV: begin
                cnt_d = w_cnt_dec;
                if (!enable_i) begin
                    stop_d = 1'b1;
                end
                if (core_valid_i) begin
                    smp_d = smp_q + 1'b1;
                    if (stop_q || !enable_i) begin
                        // Disabled mid-conversion: finish quietly, no done.
                        state_d = S_IDLE;
                    end else if (burst_mode_i && (smp_q + 1'b1 == blen_sh_q)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
`ifdef LTC2324_SCHED_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    w_to_set = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear wins over a same-cycle increment.
        if (clr_stat_i) begin
            ovr_d = '0;
        end else if (w_ovr_inc && (ovr_q != '1)) begin
            ovr_d = ovr_q + 1'b1;
        end else begin
            ovr_d = ovr_q;
        end

`ifdef LTC2324_SCHED_TIMEOUT_EN
        if (clr_stat_i) begin
            terr_d = 1'b0;
        end else if (w_to_set) begin
            terr_d = 1'b1;
        end else begin
            terr_d = terr_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= '0;
            per_sh_q  <= '0;
            blen_sh_q <= '0;
            cnt_q     <= '0;
            smp_q     <= '0;
            stop_q    <= 1'b0;
`ifdef LTC2324_SCHED_TIMEOUT_EN
            wd_q      <= '0;
            terr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            per_sh_q  <= per_sh_d;
            blen_sh_q <= blen_sh_d;
            cnt_q     <= cnt_d;
            smp_q     <= smp_d;
            stop_q    <= stop_d;
`ifdef LTC2324_SCHED_TIMEOUT_EN
            wd_q      <= wd_d;
            terr_q    <= terr_d;
`endif
        end
    end

    assign start_o       = start_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != S_IDLE);
    assign overrun_cnt_o = ovr_q;

`ifdef LTC2324_SCHED_TIMEOUT_EN
    assign timeout_err_o = terr_q;
`else
    // No watchdog in this build; the expression folds to constant 0 while
    // still referencing TIMEOUT_CYC.
    assign timeout_err_o = (TIMEOUT_CYC < 0);
`endif

endmodule
`default_nettype wire
